// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe board/turn controller: accepts a move, writes it, then spends one CHECK cycle on the detector result.
// Accepted move acks on the next cycle; move_ready drops during CHECK and stays low in OVER (sender must hold).
module ttt_board_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    input  logic        winner_in,
    input  logic [1:0]  who_in,
    output logic        move_ready,
    output logic        move_ack,
    output logic        move_err,
    output logic [17:0] board,
    output logic [1:0]  turn,
    output logic [3:0]  move_count,
    output logic        game_over,
    output logic        draw,
    output logic [1:0]  result
);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;
    state_t state;

    // Positions above 8 match no cell, so they fall out as illegal here.
    logic cell_empty;
    always_comb begin
        cell_empty = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (move_pos == 4'(i)) begin
                cell_empty = (board[2*i +: 2] == 2'b00);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state      <= PLAY;
            board      <= '0;
            turn       <= 2'b01;
            move_count <= '0;
            move_ready <= 1'b1;
            move_ack   <= 1'b0;
            move_err   <= 1'b0;
            game_over  <= 1'b0;
            draw       <= 1'b0;
            result     <= 2'b00;
        end else begin
            move_ack <= 1'b0;
            move_err <= 1'b0;
            case (state)
                PLAY: begin
                    if (move_valid) begin
                        if (cell_empty) begin
                            for (int i = 0; i < 9; i++) begin
                                if (move_pos == 4'(i)) begin
                                    board[2*i +: 2] <= turn;
                                end
                            end
                            move_count <= move_count + 4'd1;
                            move_ack   <= 1'b1;
                            move_ready <= 1'b0;
                            state      <= CHECK;
                        end else begin
                            move_err <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (winner_in) begin
                        result    <= who_in;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (move_count == 4'd9) begin
                        draw      <= 1'b1;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        turn       <= (turn == 2'b01) ? 2'b10 : 2'b01;
                        move_ready <= 1'b1;
                        state      <= PLAY;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Bench for ttt_board_ctrl: models the eight line detectors and scoreboards ack/err and game-over events.
module tb_ttt_board_ctrl;

    logic        clk = 1'b0;
    logic        rst, new_game, move_valid, winner_in;
    logic [3:0]  move_pos;
    logic [1:0]  who_in;
    logic        move_ready, move_ack, move_err, game_over, draw;
    logic [17:0] board;
    logic [1:0]  turn, result;
    logic [3:0]  move_count;

    ttt_board_ctrl dut (
        .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
        .move_pos(move_pos), .winner_in(winner_in), .who_in(who_in),
        .move_ready(move_ready), .move_ack(move_ack), .move_err(move_err),
        .board(board), .turn(turn), .move_count(move_count),
        .game_over(game_over), .draw(draw), .result(result)
    );

    always #5 clk = ~clk;

    // Stand-in for the eight 3-cell line detectors.
    function automatic logic [2:0] detect(input logic [17:0] b);
        logic [1:0] c [9];
        logic [2:0] r;
        for (int i = 0; i < 9; i++) c[i] = b[2*i +: 2];
        r = 3'b000;
        if (c[0] != 0 && c[0] == c[1] && c[1] == c[2]) r = {1'b1, c[0]};
        if (c[3] != 0 && c[3] == c[4] && c[4] == c[5]) r = {1'b1, c[3]};
        if (c[6] != 0 && c[6] == c[7] && c[7] == c[8]) r = {1'b1, c[6]};
        if (c[0] != 0 && c[0] == c[3] && c[3] == c[6]) r = {1'b1, c[0]};
        if (c[1] != 0 && c[1] == c[4] && c[4] == c[7]) r = {1'b1, c[1]};
        if (c[2] != 0 && c[2] == c[5] && c[5] == c[8]) r = {1'b1, c[2]};
        if (c[0] != 0 && c[0] == c[4] && c[4] == c[8]) r = {1'b1, c[0]};
        if (c[2] != 0 && c[2] == c[4] && c[4] == c[6]) r = {1'b1, c[2]};
        return r;
    endfunction

    always_comb {winner_in, who_in} = detect(board);

    typedef struct packed {
        logic        is_ack;
        logic [17:0] brd;
        logic [3:0]  cnt;
        logic [1:0]  trn;
    } resp_t;

    typedef struct packed {
        logic [1:0] res;
        logic       drw;
        logic [3:0] cnt;
    } over_t;

    resp_t resp_q[$];
    over_t over_q[$];
    int    checks = 0;
    int    failures = 0;
    logic  prev_over = 1'b0;

    logic [17:0] m_board;
    logic [1:0]  m_turn;
    logic [3:0]  m_count;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every ack/err pulse and every game_over rise consumes one expected entry.
    always @(negedge clk) begin
        resp_t e;
        over_t o;
        if (move_ack || move_err) begin
            checks++;
            if (resp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp ack=%0b err=%0b expected no response", move_ack, move_err);
            end else begin
                e = resp_q.pop_front();
                if ({move_ack, move_err, board, move_count, turn} !== {e.is_ack, !e.is_ack, e.brd, e.cnt, e.trn}) begin
                    failures++;
                    $display("FAIL resp ack=%0b err=%0b board=%h cnt=%0d turn=%0d expected ack=%0b err=%0b board=%h cnt=%0d turn=%0d",
                             move_ack, move_err, board, move_count, turn,
                             e.is_ack, !e.is_ack, e.brd, e.cnt, e.trn);
                end
            end
        end
        if (game_over && !prev_over) begin
            checks++;
            if (over_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_over result=%0d draw=%0b expected still playing", result, draw);
            end else begin
                o = over_q.pop_front();
                if ({result, draw, move_count} !== {o.res, o.drw, o.cnt}) begin
                    failures++;
                    $display("FAIL over result=%0d draw=%0b cnt=%0d expected result=%0d draw=%0b cnt=%0d",
                             result, draw, move_count, o.res, o.drw, o.cnt);
                end
            end
        end
        prev_over = game_over;
    end

    task automatic reset_model();
        m_board = '0;
        m_turn  = 2'b01;
        m_count = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_board"}, 32'(board), 32'h0);
        chk({tag, "_turn"}, 32'(turn), 32'h1);
        chk({tag, "_count"}, 32'(move_count), 32'h0);
        chk({tag, "_outs"}, {27'h0, move_ready, move_ack, move_err, game_over, draw}, 32'b10000);
        chk({tag, "_result"}, 32'(result), 32'h0);
    endtask

    // outcome: 0 play continues, 1 mover wins, 2 draw
    task automatic do_move(input logic [3:0] pos, input logic exp_legal, input int outcome);
        int n = 0;
        int p = int'(pos);
        while (!move_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!move_ready) begin
            chk("ready_timeout", 32'(move_ready), 32'h1);
            return;
        end
        if (exp_legal) begin
            m_board[2*p +: 2] = m_turn;
            m_count = m_count + 4'd1;
        end
        resp_q.push_back('{exp_legal, m_board, m_count, m_turn});
        move_valid = 1'b1;
        move_pos   = pos;
        @(posedge clk); #1;
        move_valid = 1'b0;
        if (!exp_legal) begin
            chk("ready_after_err", 32'(move_ready), 32'h1);
            chk("turn_after_err", 32'(turn), 32'(m_turn));
            return;
        end
        chk("ready_in_check", 32'(move_ready), 32'h0);
        if (outcome != 0)
            over_q.push_back('{(outcome == 1) ? m_turn : 2'b00, outcome == 2, m_count});
        @(posedge clk); #1;
        if (outcome == 0) begin
            m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
            chk("ready_after_check", 32'(move_ready), 32'h1);
            chk("game_over_play", 32'(game_over), 32'h0);
        end else begin
            chk("ready_in_over", 32'(move_ready), 32'h0);
        end
        chk("turn_after_check", 32'(turn), 32'(m_turn));
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        reset_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] plist [4];
        int idx, edges;

        rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_pos = '0;
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset("reset");

        // Top row win for player 1.
        do_move(4'd0, 1'b1, 0);
        do_move(4'd3, 1'b1, 0);
        do_move(4'd1, 1'b1, 0);
        do_move(4'd4, 1'b1, 0);
        do_move(4'd2, 1'b1, 1);
        chk("win_board", 32'(board), 32'(18'b00_00_00_00_10_10_01_01_01));
        chk("win_low6", 32'(board[5:0]), 32'b010101);
        chk("win_result", {29'h0, result, draw}, {29'h0, 2'b01, 1'b0});

        // Valid held in OVER: monitor rejects any ack/err.
        move_valid = 1'b1; move_pos = 4'd5;
        repeat (4) @(posedge clk);
        #1 move_valid = 1'b0;
        chk("over_hold_count", 32'(move_count), 32'd5);
        chk("over_hold_go", 32'(game_over), 32'h1);

        do_new_game();
        chk_reset("ng_over");

        // Occupied cell and out-of-range positions.
        do_move(4'd0, 1'b1, 0);
        do_move(4'd4, 1'b1, 0);
        do_move(4'd4, 1'b0, 0);
        do_move(4'd9, 1'b0, 0);
        do_move(4'd15, 1'b0, 0);
        chk("illegal_count", 32'(move_count), 32'd2);
        chk("illegal_turn", 32'(turn), 32'h1);

        // new_game beats a simultaneous legal move; no ack expected.
        new_game = 1'b1; move_valid = 1'b1; move_pos = 4'd5;
        @(posedge clk); #1;
        new_game = 1'b0; move_valid = 1'b0;
        reset_model();
        chk_reset("ng_move");

        // Full-board draw.
        do_move(4'd0, 1'b1, 0);
        do_move(4'd1, 1'b1, 0);
        do_move(4'd2, 1'b1, 0);
        do_move(4'd4, 1'b1, 0);
        do_move(4'd3, 1'b1, 0);
        do_move(4'd5, 1'b1, 0);
        do_move(4'd7, 1'b1, 0);
        do_move(4'd6, 1'b1, 0);
        do_move(4'd8, 1'b1, 2);
        chk("draw_board", 32'(board), 32'(18'b01_01_10_10_10_01_01_10_01));
        chk("draw_flags", {28'h0, game_over, draw, result}, {28'h0, 1'b1, 1'b1, 2'b00});
        chk("draw_count", 32'(move_count), 32'd9);

        do_new_game();
        chk_reset("ng_draw");

        // move_valid held continuously: one acceptance every second edge.
        plist[0] = 4'd0; plist[1] = 4'd3; plist[2] = 4'd1; plist[3] = 4'd4;
        for (int k = 0; k < 4; k++) begin
            m_board[2*int'(plist[k]) +: 2] = m_turn;
            m_count = m_count + 4'd1;
            resp_q.push_back('{1'b1, m_board, m_count, m_turn});
            m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
        end
        idx = 0; edges = 0;
        move_valid = 1'b1; move_pos = plist[0];
        while (idx < 4 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (move_ack) begin
                idx++;
                if (idx < 4) move_pos = plist[idx];
            end
        end
        move_valid = 1'b0;
        chk("held_edges", 32'(edges), 32'd7);
        @(posedge clk); #1;
        chk("held_turn", 32'(turn), 32'h1);
        chk("held_ready", 32'(move_ready), 32'h1);

        // rst while the accepted move is in CHECK.
        m_board[17:16] = m_turn;
        m_count = m_count + 4'd1;
        resp_q.push_back('{1'b1, m_board, m_count, m_turn});
        move_valid = 1'b1; move_pos = 4'd8;
        @(posedge clk); #1;
        move_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        reset_model();
        chk_reset("rst_check");

        repeat (3) @(posedge clk);
        #1;
        chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
        chk("over_q_empty", 32'(over_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
